lcd_driver: RTL and testbench

Write-only HD44780-compatible character-LCD driver in 8-bit parallel mode. It serves the LCD port of the instruction decoder: it accepts one print request (`strt`), optionally positions the cursor (`loc_req`, `data_loc`), then writes one character (`lcd_data`). It pulses `lcd_done` when the panel has accepted the byte. It also runs the panel power-up initialisation sequence autonomously after reset.

---
 rtl/lcd_req_if.sv | 20 ++
 rtl/lcd_driver.sv | 174 +++++++++++++++++
 tb/tb_lcd_driver.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_req_if.sv
// Request/handshake bundle between the instruction decoder and the LCD driver.
// Bit 7 of data_loc travels with the bus but the driver ignores it.
interface lcd_req_if;
  logic       strt;
  logic [7:0] lcd_data;
  logic [7:0] data_loc;
  logic       loc_req;
  logic       lcd_done;
  logic       lcd_busy;

  modport master (
    output strt, lcd_data, data_loc, loc_req,
    input  lcd_done, lcd_busy
  );

  modport slave (
    input  strt, lcd_data, data_loc, loc_req,
    output lcd_done, lcd_busy
  );
endinterface

// File: rtl/lcd_driver.sv
// Write-only HD44780 driver, 8-bit mode: power-up init, then one optionally
// positioned character per request. Every panel byte runs SETUP -> E_HIGH -> WAIT.
module lcd_driver #(
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int PWRUP_CYC    = 750000
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  lcd_req_if.slave   req,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  localparam int MAX_AB  = (E_PULSE_CYC > CMD_WAIT_CYC) ? E_PULSE_CYC : CMD_WAIT_CYC;
  localparam int MAX_CD  = (CLR_WAIT_CYC > PWRUP_CYC) ? CLR_WAIT_CYC : PWRUP_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [3:0] {
    S_PWRUP, S_INIT0, S_INIT1, S_INIT2, S_INIT3,
    S_IDLE, S_ADDR, S_DATA, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_EHIGH, PH_WAIT} phase_t;

  state_t             state_q;
  phase_t             phase_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               e_q, rs_q, done_q, busy_q;
  logic [7:0]         db_q;
  logic               pend_q;
  logic [7:0]         data_q;
  logic [6:0]         loc_q;
  logic               lreq_q;

  logic               in_init;
  logic               pend_d;
  logic [7:0]         data_d;
  logic [6:0]         loc_d;
  logic               lreq_d;

  // A strobe landing on the very edge INIT3 completes still counts as pending.
  assign in_init = (state_q == S_PWRUP) || (state_q == S_INIT0) || (state_q == S_INIT1) ||
                   (state_q == S_INIT2) || (state_q == S_INIT3);
  assign pend_d  = req.strt | pend_q;
  assign data_d  = req.strt ? req.lcd_data       : data_q;
  assign loc_d   = req.strt ? req.data_loc[6:0]  : loc_q;
  assign lreq_d  = req.strt ? req.loc_req        : lreq_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_PWRUP;
      phase_q <= PH_SETUP;
      cnt_q   <= CNT_W'(PWRUP_CYC - 1);
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      pend_q  <= 1'b0;
      data_q  <= 8'h00;
      loc_q   <= 7'h00;
      lreq_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_init) begin
        pend_q <= pend_d;
        data_q <= data_d;
        loc_q  <= loc_d;
        lreq_q <= lreq_d;
      end

      case (state_q)
        S_PWRUP: begin
          if (cnt_q == '0) begin
            state_q <= S_INIT0;
            phase_q <= PH_SETUP;
            rs_q    <= 1'b0;
            db_q    <= 8'h38;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_IDLE: begin
          if (req.strt) begin
            data_q  <= req.lcd_data;
            loc_q   <= req.data_loc[6:0];
            lreq_q  <= req.loc_req;
            state_q <= req.loc_req ? S_ADDR : S_DATA;
            phase_q <= PH_SETUP;
            rs_q    <= ~req.loc_req;
            db_q    <= req.loc_req ? {1'b1, req.data_loc[6:0]} : req.lcd_data;
            busy_q  <= 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          case (phase_q)
            PH_SETUP: begin
              phase_q <= PH_EHIGH;
              e_q     <= 1'b1;
              cnt_q   <= CNT_W'(E_PULSE_CYC - 1);
            end

            PH_EHIGH: begin
              if (cnt_q == '0) begin
                e_q     <= 1'b0;
                phase_q <= PH_WAIT;
                // Clear Display needs the long settle time; a data byte 0x01 does not.
                cnt_q   <= (!rs_q && db_q == 8'h01) ? CNT_W'(CLR_WAIT_CYC - 1)
                                                    : CNT_W'(CMD_WAIT_CYC - 1);
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end

            PH_WAIT: begin
              if (cnt_q == '0) begin
                phase_q <= PH_SETUP;
                case (state_q)
                  S_INIT0: begin state_q <= S_INIT1; db_q <= 8'h0C; end
                  S_INIT1: begin state_q <= S_INIT2; db_q <= 8'h01; end
                  S_INIT2: begin state_q <= S_INIT3; db_q <= 8'h06; end
                  S_INIT3: begin
                    if (pend_d) begin
                      pend_q  <= 1'b0;
                      state_q <= lreq_d ? S_ADDR : S_DATA;
                      rs_q    <= ~lreq_d;
                      db_q    <= lreq_d ? {1'b1, loc_d} : data_d;
                    end else begin
                      state_q <= S_IDLE;
                      busy_q  <= 1'b0;
                    end
                  end
                  S_ADDR: begin
                    state_q <= S_DATA;
                    rs_q    <= 1'b1;
                    db_q    <= data_q;
                  end
                  default: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                  end
                endcase
              end else begin
                cnt_q <= cnt_q - 1'b1;
              end
            end

            default: phase_q <= PH_SETUP;
          endcase
        end
      endcase
    end
  end

  assign lcd_e        = e_q;
  assign lcd_rs       = rs_q;
  assign lcd_rw       = 1'b0;
  assign lcd_db       = db_q;
  assign req.lcd_done = done_q;
  assign req.lcd_busy = busy_q;

endmodule

// File: tb/tb_lcd_driver.sv
// Scoreboard bench for lcd_driver: stimulus pushes expected panel bytes and
// lcd_done cycles; a negedge monitor pops and compares as the panel is strobed.
module tb_lcd_driver;
  localparam int E   = 2;
  localparam int CMD = 4;
  localparam int CLR = 8;
  localparam int PWR = 10;
  localparam int B        = 1 + E + CMD;
  localparam int BCLR     = 1 + E + CLR;
  localparam int INIT_LEN = PWR + 3 * B + BCLR;

  logic       clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  lcd_req_if bus();

  lcd_driver #(
    .E_PULSE_CYC (E),
    .CMD_WAIT_CYC(CMD),
    .CLR_WAIT_CYC(CLR),
    .PWRUP_CYC   (PWR)
  ) dut (
    .clk      (clk),
    .sys_rst_n(sys_rst_n),
    .req      (bus),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_db   (lcd_db)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] exp_bytes[$];
  int         exp_done[$];
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push_init();
    exp_bytes.push_back({1'b0, 8'h38});
    exp_bytes.push_back({1'b0, 8'h0C});
    exp_bytes.push_back({1'b0, 8'h01});
    exp_bytes.push_back({1'b0, 8'h06});
  endtask

  // Monitor: one line per panel byte and per completion
  logic       prev_e = 1'b0;
  int         hi_len = 0;
  logic [8:0] hi_byte = '0;
  logic [8:0] want_byte;
  int         want_cyc;

  always @(negedge clk) begin
    if (!sys_rst_n) begin
      prev_e = 1'b0;
      hi_len = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        hi_len  = 1;
        hi_byte = {lcd_rs, lcd_db};
        $display("byte rs=%0d db=0x%02h @%0d", lcd_rs, lcd_db, cyc);
        check("rw_low", {31'd0, lcd_rw}, 32'd0);
        if (exp_bytes.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got 0x%0h, expected none", {lcd_rs, lcd_db});
        end else begin
          want_byte = exp_bytes.pop_front();
          check("panel_byte", {23'd0, lcd_rs, lcd_db}, {23'd0, want_byte});
        end
      end else if (lcd_e) begin
        hi_len++;
      end else if (prev_e) begin
        check("e_width", hi_len, E);
        check("bus_hold", {23'd0, lcd_rs, lcd_db}, {23'd0, hi_byte});
      end
      if (bus.lcd_done) begin
        $display("done @%0d", cyc);
        if (exp_done.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done at %0d, expected none", cyc);
        end else begin
          want_cyc = exp_done.pop_front();
          check("done_cycle", cyc, want_cyc);
        end
      end
      prev_e = lcd_e;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.lcd_busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (bus.lcd_busy) begin
      n_checks++;
      $display("FAIL idle_timeout: got busy=1, expected busy=0 within 400 cycles");
    end
  endtask

  // Reference model: ADDR byte is 0x80|loc, data byte follows; one byte = B cycles.
  task automatic issue(input logic [7:0] d, input logic [7:0] loc, input logic lr);
    bus.strt     = 1'b1;
    bus.lcd_data = d;
    bus.data_loc = loc;
    bus.loc_req  = lr;
    if (lr) exp_bytes.push_back({1'b0, 8'h80 | {1'b0, loc[6:0]}});
    exp_bytes.push_back({1'b1, d});
    exp_done.push_back(cyc + 1 + (lr ? 2 * B : B));
    tick();
    bus.strt     = 1'b0;
    bus.lcd_data = 8'($urandom);
    bus.data_loc = 8'($urandom);
    bus.loc_req  = 1'($urandom);
  endtask

  task automatic stray_pulse(input logic [7:0] d);
    bus.strt     = 1'b1;
    bus.lcd_data = d;
    bus.loc_req  = 1'b0;
    tick();
    bus.strt = 1'b0;
  endtask

  int r;
  int n;
  int k;

  initial begin
    bus.strt = 1'b0; bus.lcd_data = 8'h00; bus.data_loc = 8'h00; bus.loc_req = 1'b0;
    repeat (2) tick();
    check("rst_e",    {31'd0, lcd_e},        32'd0);
    check("rst_rs",   {31'd0, lcd_rs},       32'd0);
    check("rst_rw",   {31'd0, lcd_rw},       32'd0);
    check("rst_db",   {24'd0, lcd_db},       32'd0);
    check("rst_done", {31'd0, bus.lcd_done}, 32'd0);
    check("rst_busy", {31'd0, bus.lcd_busy}, 32'd1);

    // Init with two requests during init: only the last one is serviced
    push_init();
    sys_rst_n = 1'b1;
    r = cyc;
    wait_until(r + 4);
    stray_pulse(8'h31);
    wait_until(r + 19);
    stray_pulse(8'h32);
    exp_bytes.push_back({1'b1, 8'h32});
    exp_done.push_back(r + INIT_LEN + B);
    wait_until(r + INIT_LEN - 1);
    check("init_busy_before_end", {31'd0, bus.lcd_busy}, 32'd1);
    tick();
    check("init_busy_pending", {31'd0, bus.lcd_busy}, 32'd1);
    wait_idle();

    tick();
    issue(8'h41, 8'h00, 1'b0);
    wait_idle();
    issue(8'h5A, 8'hC5, 1'b1);
    wait_idle();

    // A request 3 cycles into a transfer is dropped
    issue(8'h42, 8'h00, 1'b0);
    repeat (2) tick();
    stray_pulse(8'h99);
    wait_idle();

    // Held strt: sampled again in the IDLE cycle after DONE
    bus.strt = 1'b1; bus.lcd_data = 8'h55; bus.loc_req = 1'b0;
    n = cyc + 1;
    exp_bytes.push_back({1'b1, 8'h55});
    exp_bytes.push_back({1'b1, 8'h55});
    exp_done.push_back(n + B);
    exp_done.push_back(n + 2 * B + 2);
    wait_until(n + B + 2);
    bus.strt = 1'b0;
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      issue(8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat (2) tick();
        stray_pulse(8'($urandom));
      end
      wait_idle();
    end

    // Reset while E is high
    tick();
    issue(8'h77, 8'h00, 1'b0);
    k = 0;
    while (!lcd_e && k < 50) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("e_seen_before_reset", {31'd0, lcd_e}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("abort_e",    {31'd0, lcd_e},        32'd0);
    check("abort_busy", {31'd0, bus.lcd_busy}, 32'd1);
    check("abort_db",   {24'd0, lcd_db},       32'd0);
    exp_bytes.delete();
    exp_done.delete();
    repeat (2) tick();
    push_init();
    sys_rst_n = 1'b1;
    r = cyc;
    wait_until(r + INIT_LEN - 1);
    check("reinit_busy_before_end", {31'd0, bus.lcd_busy}, 32'd1);
    tick();
    check("reinit_busy_fall", {31'd0, bus.lcd_busy}, 32'd0);
    issue(8'h23, 8'h00, 1'b0);
    wait_idle();
    repeat (3) tick();

    check("bytes_left", exp_bytes.size(), 32'd0);
    check("dones_left", exp_done.size(),  32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
